// File: rtl/tdc_frame_ctrl_if.sv
// Readout stream between the frame controller and the AXI-stream packer.
// One beat carries a tof value and its intensity; out_last marks the final
// beat of a frame.
interface tdc_frame_ctrl_if #(
  parameter int TOF_W = 10,
  parameter int INT_W = 5
);
  logic [TOF_W-1:0] out_data;
  logic [INT_W-1:0] out_int;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;

  modport master (
    output out_data,
    output out_int,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_int,
    input  out_valid,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/tdc_frame_ctrl.sv
// Frame sequencer and readout controller for the TDC core.
// Starts a frame, waits for the end-of-window interrupt (with timeout),
// snapshots the stored results and streams them highest intensity first.
module tdc_frame_ctrl #(
  parameter int TOF_W     = 10,
  parameter int INT_W     = 5,
  parameter int DEPTH     = 3,
  parameter int FRAME_GAP = 16,
  parameter int TIMEOUT   = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   single,
  output logic                   tdc_start,
  input  logic                   tdc_int,
  input  logic [1:0]             res_num,
  input  logic [DEPTH*TOF_W-1:0] res_tof,
  input  logic [DEPTH*INT_W-1:0] res_int,
  tdc_frame_ctrl_if.master       out_if,
  output logic                   busy,
  output logic [7:0]             frame_id,
  output logic                   timeout_err
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] LATCH = 3'd3;
  localparam logic [2:0] SEND  = 3'd4;
  localparam logic [2:0] GAP   = 3'd5;

  localparam logic [1:0] DEPTH_C  = 2'(DEPTH);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  localparam int         GAP_W    = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(FRAME_GAP - 1);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

  logic [2:0]       state_r;
  logic [2:0]       state_s;
  logic [7:0]       tmo_cnt_r;
  logic             tmo_flag_r;
  logic [GAP_W-1:0] gap_cnt_r;

  // Frame snapshot taken in LATCH
  logic [TOF_W-1:0] tof_r [DEPTH];
  logic [INT_W-1:0] int_r [DEPTH];
  logic [1:0]       num_r;
  logic [DEPTH-1:0] sent_r;
  logic [1:0]       idx_r;

  logic             tdc_start_r;
  logic             busy_r;
  logic             timeout_err_r;
  logic [7:0]       frame_id_r;
  logic             out_valid_r;
  logic             out_last_r;
  logic [TOF_W-1:0] out_data_r;
  logic [INT_W-1:0] out_int_r;

  logic             tmo_hit_s;
  logic             tmo_evt_s;
  logic             gap_hit_s;
  logic             hs_s;
  logic [1:0]       sel_idx_s;
  logic [INT_W-1:0] sel_int_s;
  logic             sel_found_s;
  logic [1:0]       rem_s;

  assign tmo_hit_s = (tmo_cnt_r == TMO_LAST);
  // tdc_int on the timeout cycle takes priority, so no error then
  assign tmo_evt_s = (state_r == WAIT) && !tdc_int && tmo_hit_s;
  assign gap_hit_s = (gap_cnt_r == GAP_LAST);
  assign hs_s      = out_valid_r & out_if.out_ready;

  // Pick the unsent valid slot with the largest intensity (lowest index on ties)
  always_comb begin
    sel_idx_s   = 2'd0;
    sel_int_s   = {INT_W{1'b0}};
    sel_found_s = 1'b0;
    rem_s       = 2'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((2'(i) < num_r) && !sent_r[i]) begin
        rem_s = rem_s + 2'd1;
        if (!sel_found_s || (int_r[i] > sel_int_s)) begin
          sel_found_s = 1'b1;
          sel_idx_s   = 2'(i);
          sel_int_s   = int_r[i];
        end else begin
          sel_found_s = sel_found_s;
        end
      end else begin
        rem_s = rem_s;
      end
    end
  end

  // Next-state decode of the frame sequencer
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (enable || single) begin
          state_s = START;
        end else begin
          state_s = IDLE;
        end
      end
      START: state_s = WAIT;
      WAIT: begin
        if (tdc_int || tmo_hit_s) begin
          state_s = LATCH;
        end else begin
          state_s = WAIT;
        end
      end
      LATCH: state_s = SEND;
      SEND: begin
        if (hs_s && out_last_r) begin
          state_s = GAP;
        end else begin
          state_s = SEND;
        end
      end
      GAP: begin
        if (gap_hit_s) begin
          if (enable) begin
            state_s = START;
          end else begin
            state_s = IDLE;
          end
        end else begin
          state_s = GAP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State, control outputs, frame counter and wait/gap counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      busy_r        <= 1'b0;
      tdc_start_r   <= 1'b0;
      timeout_err_r <= 1'b0;
      frame_id_r    <= 8'd0;
      tmo_cnt_r     <= 8'd0;
      tmo_flag_r    <= 1'b0;
      gap_cnt_r     <= {GAP_W{1'b0}};
    end else begin
      state_r       <= state_s;
      busy_r        <= (state_s != IDLE);
      tdc_start_r   <= (state_s == START);
      timeout_err_r <= tmo_evt_s;
      if (state_s == START) begin
        frame_id_r <= frame_id_r + 8'd1;
        tmo_cnt_r  <= 8'd0;
        tmo_flag_r <= 1'b0;
      end else begin
        if ((state_r == WAIT) && !tmo_hit_s) begin
          tmo_cnt_r <= tmo_cnt_r + 8'd1;
        end
        if (tmo_evt_s) begin
          tmo_flag_r <= 1'b1;
        end
      end
      if (state_r == GAP) begin
        gap_cnt_r <= gap_cnt_r + GAP_ONE;
      end else begin
        gap_cnt_r <= {GAP_W{1'b0}};
      end
    end
  end

  // Snapshot capture and registered stream beats with the sent mask
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        tof_r[i] <= {TOF_W{1'b0}};
        int_r[i] <= {INT_W{1'b0}};
      end
      num_r       <= 2'd0;
      sent_r      <= {DEPTH{1'b0}};
      idx_r       <= 2'd0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_data_r  <= {TOF_W{1'b0}};
      out_int_r   <= {INT_W{1'b0}};
    end else if (state_r == LATCH) begin
      for (int i = 0; i < DEPTH; i++) begin
        tof_r[i] <= res_tof[i*TOF_W +: TOF_W];
        int_r[i] <= res_int[i*INT_W +: INT_W];
      end
      if (tmo_flag_r) begin
        num_r <= 2'd0;
      end else if (res_num > DEPTH_C) begin
        num_r <= DEPTH_C;
      end else begin
        num_r <= res_num;
      end
      sent_r      <= {DEPTH{1'b0}};
      out_valid_r <= 1'b0;
    end else if (state_r == SEND) begin
      if (hs_s) begin
        if (num_r != 2'd0) begin
          sent_r[idx_r] <= 1'b1;
        end
        out_valid_r <= 1'b0;
        out_last_r  <= 1'b0;
        out_data_r  <= {TOF_W{1'b0}};
        out_int_r   <= {INT_W{1'b0}};
      end else if (!out_valid_r) begin
        // An empty frame still sends one zero beat flagged last
        out_valid_r <= 1'b1;
        out_last_r  <= (rem_s <= 2'd1);
        idx_r       <= sel_idx_s;
        if (num_r == 2'd0) begin
          out_data_r <= {TOF_W{1'b0}};
          out_int_r  <= {INT_W{1'b0}};
        end else begin
          out_data_r <= tof_r[sel_idx_s];
          out_int_r  <= int_r[sel_idx_s];
        end
      end
    end else begin
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_data_r  <= {TOF_W{1'b0}};
      out_int_r   <= {INT_W{1'b0}};
    end
  end

  assign tdc_start        = tdc_start_r;
  assign busy             = busy_r;
  assign frame_id         = frame_id_r;
  assign timeout_err      = timeout_err_r;
  assign out_if.out_valid = out_valid_r;
  assign out_if.out_last  = out_last_r;
  assign out_if.out_data  = out_data_r;
  assign out_if.out_int   = out_int_r;

endmodule

// File: tb/tb_tdc_frame_ctrl.sv
// Scoreboard bench: two controllers (DEPTH=3 and DEPTH=2) share stimulus;
// expected beats come from a sorting model and are popped by a monitor.
module tb_tdc_frame_ctrl;
  localparam int TW = 10;
  localparam int IW = 5;

  typedef struct packed {
    logic [9:0] tof;
    logic [4:0] in;
    logic       last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n, enable, single, tdc_int, ready;
  logic [1:0]  res_num;
  logic [29:0] res_tof;
  logic [14:0] res_int;
  logic start3, start2, busy3, busy2, terr3, terr2;
  logic [7:0] fid3, fid2;

  int total = 0;
  int bad = 0;
  beat_t q3[$];
  beat_t q2[$];
  int m_tof[3];
  int m_int[3];
  int exp_fid = 0;
  int exp_terr = 0;
  int start_cnt = 0;
  int terr_cnt = 0;
  int rmode = 0;
  int cyc = 0;
  logic  stall_p[2];
  beat_t held_p[2];

  tdc_frame_ctrl_if #(.TOF_W(TW), .INT_W(IW)) if3 ();
  tdc_frame_ctrl_if #(.TOF_W(TW), .INT_W(IW)) if2 ();
  assign if3.out_ready = ready;
  assign if2.out_ready = ready;

  tdc_frame_ctrl #(.TOF_W(TW), .INT_W(IW), .DEPTH(3), .FRAME_GAP(16), .TIMEOUT(255)) dut3 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .single(single),
    .tdc_start(start3), .tdc_int(tdc_int), .res_num(res_num),
    .res_tof(res_tof), .res_int(res_int), .out_if(if3.master),
    .busy(busy3), .frame_id(fid3), .timeout_err(terr3)
  );

  tdc_frame_ctrl #(.TOF_W(TW), .INT_W(IW), .DEPTH(2), .FRAME_GAP(16), .TIMEOUT(255)) dut2 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .single(single),
    .tdc_start(start2), .tdc_int(tdc_int), .res_num(res_num),
    .res_tof(res_tof[19:0]), .res_int(res_int[9:0]), .out_if(if2.master),
    .busy(busy2), .frame_id(fid2), .timeout_err(terr2)
  );

  // 250 MHz logic clock
  always #2 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int w, input beat_t b);
    if (w == 0) q3.push_back(b);
    else q2.push_back(b);
  endtask

  // Reference: stable order by intensity descending, index ascending
  task automatic model(input int w, input int depth, input int rn, input bit tmo);
    int n;
    int k;
    beat_t b;
    n = tmo ? 0 : ((rn < depth) ? rn : depth);
    if (n == 0) begin
      b = {10'd0, 5'd0, 1'b1};
      push(w, b);
    end else begin
      k = 0;
      for (int v = 31; v >= 0; v--) begin
        for (int i = 0; i < n; i++) begin
          if (m_int[i] == v) begin
            k++;
            b = {10'(m_tof[i]), 5'(m_int[i]), (k == n) ? 1'b1 : 1'b0};
            push(w, b);
          end
        end
      end
    end
  endtask

  task automatic set_res(input int rn, input int t0, input int t1, input int t2,
                         input int i0, input int i1, input int i2);
    m_tof[0] = t0; m_tof[1] = t1; m_tof[2] = t2;
    m_int[0] = i0; m_int[1] = i1; m_int[2] = i2;
    res_num = 2'(rn);
    res_tof = {10'(t2), 10'(t1), 10'(t0)};
    res_int = {5'(i2), 5'(i1), 5'(i0)};
  endtask

  task automatic mon(input int w, input logic v, input logic [9:0] d,
                     input logic [4:0] n, input logic l);
    beat_t cur;
    beat_t e;
    bit empty;
    cur = {d, n, l};
    if (stall_p[w]) begin
      chk($sformatf("hold_valid_d%0d", w), v, 1);
      chk($sformatf("hold_beat_d%0d", w), cur, held_p[w]);
    end
    if (v && ready) begin
      empty = (w == 0) ? (q3.size() == 0) : (q2.size() == 0);
      if (empty) begin
        total++;
        bad++;
        $display("FAIL unexpected_beat_d%0d: got tof=%0d int=%0d, expected no beat", w, d, n);
      end else begin
        if (w == 0) e = q3.pop_front();
        else e = q2.pop_front();
        chk($sformatf("beat_tof_d%0d", w), d, e.tof);
        chk($sformatf("beat_int_d%0d", w), n, e.in);
        chk($sformatf("beat_last_d%0d", w), l, e.last);
      end
    end
    stall_p[w] = v && !ready;
    held_p[w] = cur;
  endtask

  // Monitor: compare beats on the falling edge, count start and timeout pulses
  initial begin
    stall_p[0] = 1'b0;
    stall_p[1] = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_p[0] = 1'b0;
        stall_p[1] = 1'b0;
      end else begin
        mon(0, if3.out_valid, if3.out_data, if3.out_int, if3.out_last);
        mon(1, if2.out_valid, if2.out_data, if2.out_int, if2.out_last);
        if (start3) start_cnt++;
        if (terr3) terr_cnt++;
      end
    end
  end

  // Cycle counter for start spacing
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Ready driver: 0 always ready, 1 random, 2 five low cycles then one high
  initial begin
    int ph;
    ph = 0;
    ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ph++;
      case (rmode)
        1: ready = 1'($urandom_range(0, 1));
        2: ready = ((ph % 6) == 0);
        default: ready = 1'b1;
      endcase
    end
  end

  task automatic wait_idle(input bit noise);
    int n;
    n = 0;
    while ((busy3 || busy2) && n < 3000) begin
      tdc_int = (noise && ($urandom_range(0, 7) == 0)) ? 1'b1 : 1'b0;
      tick();
      n++;
    end
    tdc_int = 1'b0;
    chk("idle_reached", {busy3, busy2}, 0);
  endtask

  task automatic run_frame(input int dly, input bit tmo, input bit noise);
    int n;
    model(0, 3, int'(res_num), tmo);
    model(1, 2, int'(res_num), tmo);
    exp_fid++;
    single = 1'b1;
    tick();
    single = 1'b0;
    chk("start_pulse_d3", start3, 1);
    chk("start_pulse_d2", start2, 1);
    chk("frame_id_d3", fid3, exp_fid % 256);
    chk("frame_id_d2", fid2, exp_fid % 256);
    tick();
    if (tmo) begin
      n = 0;
      while (!terr3 && n < 400) begin
        tick();
        n++;
      end
      chk("timeout_cycles", n, 255);
      chk("timeout_err_d2", terr2, 1);
      exp_terr++;
      tick();
      chk("timeout_pulse_width", terr3, 0);
    end else begin
      repeat (dly - 1) tick();
      tdc_int = 1'b1;
      tick();
      tdc_int = 1'b0;
    end
    wait_idle(noise);
    chk("queue_empty_d3", q3.size(), 0);
    chk("queue_empty_d2", q2.size(), 0);
    chk("start_count", start_cnt, exp_fid);
    chk("timeout_count", terr_cnt, exp_terr);
  endtask

  initial begin
    int n;
    int prev;
    rst_n = 1'b0;
    enable = 1'b0;
    single = 1'b0;
    tdc_int = 1'b0;
    set_res(0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    chk("rst_valid", if3.out_valid, 0);
    chk("rst_start", start3, 0);
    chk("rst_busy", busy3, 0);
    chk("rst_frame_id", fid3, 0);
    chk("rst_terr", terr3, 0);
    rst_n = 1'b1;
    tick();

    // Three results, distinct intensities; DEPTH=2 copy clamps to two
    set_res(3, 100, 200, 300, 4, 9, 2);
    run_frame(20, 1'b0, 1'b0);

    // Tie on intensity under heavy backpressure
    rmode = 2;
    set_res(2, 11, 22, 0, 7, 7, 0);
    run_frame(10, 1'b0, 1'b0);
    rmode = 0;

    // No interrupt: timeout and empty-frame marker
    set_res(3, 1, 2, 3, 1, 2, 3);
    run_frame(0, 1'b1, 1'b0);

    // Interrupt on the timeout cycle: no error
    set_res(1, 5, 0, 0, 6, 0, 0);
    run_frame(255, 1'b0, 1'b0);

    // Random frames, random backpressure, stray interrupts after WAIT
    rmode = 1;
    repeat (6) begin
      set_res($urandom_range(0, 3), $urandom_range(0, 1023), $urandom_range(0, 1023),
              $urandom_range(0, 1023), $urandom_range(0, 7), $urandom_range(0, 7),
              $urandom_range(0, 7));
      run_frame($urandom_range(1, 60), 1'b0, 1'b1);
    end
    rmode = 0;

    // Reset one cycle after the first beat handshake
    set_res(3, 7, 8, 9, 1, 2, 3);
    model(0, 3, 3, 1'b0);
    model(1, 2, 3, 1'b0);
    single = 1'b1;
    tick();
    single = 1'b0;
    repeat (3) tick();
    tdc_int = 1'b1;
    tick();
    tdc_int = 1'b0;
    n = 0;
    while (!if3.out_valid && n < 50) begin
      tick();
      n++;
    end
    chk("rst_test_beat1_valid", if3.out_valid, 1);
    tick();
    rst_n = 1'b0;
    q3.delete();
    q2.delete();
    tick();
    chk("midrst_valid", if3.out_valid, 0);
    chk("midrst_data", if3.out_data, 0);
    chk("midrst_int", if3.out_int, 0);
    chk("midrst_last", if3.out_last, 0);
    chk("midrst_start", start3, 0);
    chk("midrst_busy", busy3, 0);
    chk("midrst_frame_id", fid3, 0);
    chk("midrst_terr", terr3, 0);
    chk("midrst_d2", {if2.out_valid, busy2, fid2}, 0);
    rst_n = 1'b1;
    exp_fid = 0;
    start_cnt = 0;
    terr_cnt = 0;
    exp_terr = 0;
    repeat (40) tick();
    chk("postrst_busy", busy3, 0);
    chk("postrst_frame_id", fid3, 0);
    chk("postrst_starts", start_cnt, 0);

    // Continuous run of three frames, enable dropped during frame 3 SEND
    set_res(1, 0, 0, 0, 0, 0, 0);
    enable = 1'b1;
    prev = 0;
    for (int f = 1; f <= 3; f++) begin
      n = 0;
      while (!start3 && n < 200) begin
        tick();
        n++;
      end
      chk("cont_start_seen", start3, 1);
      exp_fid++;
      chk("cont_frame_id", fid3, exp_fid);
      if (f > 1) chk("cont_spacing", ((cyc - prev) >= 19) ? 1 : 0, 1);
      prev = cyc;
      set_res(1, 50 * f, 1, 2, f, 3, 4);
      model(0, 3, 1, 1'b0);
      model(1, 2, 1, 1'b0);
      repeat (5) tick();
      tdc_int = 1'b1;
      tick();
      tdc_int = 1'b0;
      if (f == 3) begin
        n = 0;
        while (!if3.out_valid && n < 50) begin
          tick();
          n++;
        end
        enable = 1'b0;
      end
    end
    wait_idle(1'b0);
    repeat (20) tick();
    chk("cont_busy_end", busy3, 0);
    chk("cont_starts", start_cnt, 3);
    chk("cont_queue_d3", q3.size(), 0);
    chk("cont_queue_d2", q2.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
